// File: rtl/delay_timer_ctrl_pkg.sv
// Shared constants for the delay timer: register map, status bit layout,
// control bits and FSM state encodings.
package delay_timer_ctrl_pkg;

   localparam logic ADDR_COUNT  = 1'b0;
   localparam logic ADDR_STAT   = 1'b1;

   localparam int   ST_DONE     = 0;
   localparam int   ST_BUSY     = 1;
   localparam int   CTRL_CANCEL = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/delay_timer_ctrl.sv
// CPU-facing delay timer: counts N generator ticks after a COUNT write,
// then raises a sticky done flag that a STATUS read clears.
module delay_timer_ctrl
   import delay_timer_ctrl_pkg::*;
#(
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic          wr,
   input  logic          rd,
   input  logic          addr,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] data_out,
   output logic          tick_en,
   input  logic          tick,
   output logic          busy,
   output logic          done,
   output logic [1:0]    state_dbg
);

   state_e        state_q, state_d;
   logic [DW-1:0] remaining_q, remaining_d;
   logic          done_q, done_d;

   logic wr_count, wr_ctrl, rd_stat;
   assign wr_count = cs & wr & (addr == ADDR_COUNT);
   assign wr_ctrl  = cs & wr & (addr == ADDR_STAT);
   assign rd_stat  = cs & rd & (addr == ADDR_STAT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
      end
   end

   // Priority, lowest to highest: status-read clear, tick/done set,
   // cancel, COUNT write. A cancel discards a coincident final tick.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      done_d      = rd_stat ? 1'b0 : done_q;
      case (state_q)
         S_ARM: state_d = S_RUN;
         S_RUN: begin
            if (tick && remaining_q != '0) begin
               remaining_d = remaining_q - {{(DW-1){1'b0}}, 1'b1};
               if (remaining_q == {{(DW-1){1'b0}}, 1'b1}) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (wr_ctrl && data_in[CTRL_CANCEL]) begin
         state_d     = S_IDLE;
         remaining_d = '0;
         done_d      = rd_stat ? 1'b0 : done_q;
      end
      if (wr_count) begin
         remaining_d = data_in;
         if (data_in != '0) begin
            state_d = S_ARM;
            done_d  = 1'b0;
         end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_comb begin
      tick_en   = (state_q == S_RUN);
      busy      = (state_q != S_IDLE);
      done      = done_q;
      state_dbg = state_q;
      data_out  = '0;
      if (cs && rd) begin
         if (addr == ADDR_COUNT) begin
            data_out = remaining_q;
         end else begin
            data_out[ST_DONE] = done_q;
            data_out[ST_BUSY] = busy;
         end
      end
   end

endmodule

// File: tb/tb_delay_timer_ctrl.sv
// Bench for delay_timer_ctrl: period-4 tick generator, directed scenarios,
// then random bus traffic checked every cycle against a reference model.
module tb_delay_timer_ctrl;

   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cs = 1'b0, wr = 1'b0, rd = 1'b0, addr = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          tick_en, tick, busy, done;
   logic [1:0]    state_dbg;
   logic          extra_tick = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   // Tick generator model: counter held at 0 while disabled, pulse every 4th enabled cycle.
   logic [1:0] gen_cnt = 2'd0;
   always @(posedge clk) begin
      if (!tick_en) gen_cnt <= 2'd0;
      else          gen_cnt <= gen_cnt + 2'd1;
   end
   assign tick = (tick_en && gen_cnt == 2'd3) | extra_tick;

   delay_timer_ctrl #(.DW(DW)) dut (
      .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
      .data_in(data_in), .data_out(data_out), .tick_en(tick_en), .tick(tick),
      .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: counting phase plus pending-arm flag, integer count.
   int m_rem     = 0;
   bit m_done    = 1'b0;
   bit m_arming  = 1'b0;
   bit m_running = 1'b0;

   always @(posedge clk) begin
      bit set_done, clr, nxt_arm, nxt_run;
      if (rst) begin
         m_rem = 0; m_done = 1'b0; m_arming = 1'b0; m_running = 1'b0;
      end else begin
         clr      = cs && rd && addr;
         set_done = 1'b0;
         nxt_arm  = 1'b0;
         nxt_run  = m_running || m_arming;
         if (m_running && tick && m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               nxt_run  = 1'b0;
               set_done = 1'b1;
            end
         end
         if (cs && wr && addr && data_in[0]) begin
            nxt_run = 1'b0; m_rem = 0; set_done = 1'b0;
         end
         if (cs && wr && !addr) begin
            m_rem   = int'(data_in);
            nxt_run = 1'b0;
            nxt_arm = (data_in != 0);
            m_done  = (data_in == 0);
         end else begin
            m_done = set_done ? 1'b1 : (clr ? 1'b0 : m_done);
         end
         m_arming  = nxt_arm;
         m_running = nxt_run;
      end
   end

   always @(negedge clk) begin
      logic [DW-1:0] exp_do;
      if (chk_on) begin
         exp_do = '0;
         if (cs && rd) exp_do = addr ? DW'({m_arming | m_running, m_done}) : DW'(m_rem);
         chk("model tick_en", 32'(tick_en), 32'(m_running));
         chk("model busy", 32'(busy), 32'(m_arming | m_running));
         chk("model done", 32'(done), 32'(m_done));
         chk("model data_out", 32'(data_out), 32'(exp_do));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 1'b0; data_in = '0;
   endtask

   task automatic write(input logic a, input logic [DW-1:0] d);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; data_in = d;
      cyc();
      bus_idle();
   endtask

   task automatic read_count(input string tag, input int exp);
      cs = 1'b1; rd = 1'b1; addr = 1'b0;
      #1;
      chk(tag, 32'(data_out), 32'(exp));
      bus_idle();
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 200) begin
         cyc();
         n++;
      end
   endtask

   int n;

   initial begin
      // 1: reset, COUNT=3
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      chk_on = 1'b1;
      chk("reset tick_en", 32'(tick_en), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      read_count("reset count", 0);
      write(1'b0, 12'd3);
      chk("t1 arm tick_en", 32'(tick_en), 0);
      chk("t1 arm busy", 32'(busy), 1);
      cyc();
      chk("t1 run tick_en", 32'(tick_en), 1);
      wait_done(n);
      chk("t1 cycles to done", 32'(n), 12);
      chk("t1 done tick_en", 32'(tick_en), 0);
      chk("t1 done busy", 32'(busy), 0);

      // 2: zero-length delay
      write(1'b0, 12'd0);
      chk("t2 done", 32'(done), 1);
      chk("t2 busy", 32'(busy), 0);
      repeat (6) begin
         cyc();
         chk("t2 tick_en low", 32'(tick_en), 0);
      end

      // 3: rewrite during RUN
      write(1'b0, 12'd5);
      cyc();
      repeat (8) cyc();
      read_count("t3 count after 2 ticks", 3);
      write(1'b0, 12'd2);
      chk("t3 rearm tick_en", 32'(tick_en), 0);
      chk("t3 rearm busy", 32'(busy), 1);
      cyc();
      read_count("t3 count 2", 2);
      repeat (4) cyc();
      read_count("t3 count 1", 1);
      wait_done(n);
      chk("t3 cycles to done", 32'(n), 4);
      read_count("t3 count 0", 0);

      // 4: STATUS read clears done; read on final tick keeps it
      cs = 1'b1; rd = 1'b1; addr = 1'b1;
      #1;
      chk("t4 status", 32'(data_out), 32'h001);
      cyc();
      bus_idle();
      chk("t4 done cleared", 32'(done), 0);
      write(1'b0, 12'd1);
      cyc();
      repeat (3) cyc();
      chk("t4 final tick", 32'(tick), 1);
      cs = 1'b1; rd = 1'b1; addr = 1'b1;
      #1;
      chk("t4 status busy", 32'(data_out), 32'h002);
      cyc();
      bus_idle();
      chk("t4 set wins", 32'(done), 1);
      chk("t4 busy after", 32'(busy), 0);

      // 5: cancel, stray ticks, tick vs write
      write(1'b0, 12'd4);
      cyc();
      repeat (4) cyc();
      read_count("t5 count 3", 3);
      write(1'b1, 12'h001);
      chk("t5 cancel busy", 32'(busy), 0);
      chk("t5 cancel tick_en", 32'(tick_en), 0);
      chk("t5 cancel done", 32'(done), 0);
      read_count("t5 cancel count", 0);
      extra_tick = 1'b1;
      repeat (3) cyc();
      extra_tick = 1'b0;
      read_count("t5 idle tick count", 0);
      chk("t5 idle tick done", 32'(done), 0);
      write(1'b0, 12'd2);
      extra_tick = 1'b1;
      cyc();
      extra_tick = 1'b0;
      read_count("t5 arm tick ignored", 2);
      extra_tick = 1'b1;
      write(1'b0, 12'd6);
      extra_tick = 1'b0;
      read_count("t5 write beats tick", 6);

      // 6: reset mid-RUN
      write(1'b0, 12'd7);
      cyc();
      read_count("t6 count 7", 7);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t6 tick_en", 32'(tick_en), 0);
      chk("t6 busy", 32'(busy), 0);
      chk("t6 done", 32'(done), 0);
      read_count("t6 count", 0);
      repeat (30) cyc();
      chk("t6 no done", 32'(done), 0);

      // Random traffic, checked each cycle by the model
      for (int i = 0; i < 1500; i++) begin
         int r;
         bus_idle();
         extra_tick = 1'b0;
         rst = 1'b0;
         r = $urandom_range(0, 199);
         if (r == 0) begin
            rst = 1'b1;
         end else if (r < 8) begin
            cs = 1'b1; wr = 1'b1; addr = 1'b0;
            data_in = DW'($urandom_range(0, 4));
         end else if (r < 10) begin
            cs = 1'b1; wr = 1'b1; addr = 1'b1;
            data_in = DW'($urandom_range(0, 7));
         end else if (r < 40) begin
            cs = 1'b1; rd = 1'b1;
            addr = 1'($urandom_range(0, 1));
            if (r < 20) wr = 1'b0;
         end else if (r < 46) begin
            extra_tick = 1'b1;
         end else if (r < 50) begin
            rd = 1'b1; addr = 1'b1;
         end
         cyc();
      end
      bus_idle();
      extra_tick = 1'b0;
      rst = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
